vga_rgb_out_stage: RTL and testbench

- Final pixel-output stage; sits directly downstream of the one-hot RGB source multiplexer.
- Registers the selected 3-bit colour (rgbnext) on each pixel tick.
- Delays hsync/vsync/video_on through a tick-enabled pipeline so they stay aligned with the colour path.
- Forces black during blanking, drives the VGA pins and keeps a frame counter for blink/animation logic.

---
 rtl/vga_rgb_out_stage.sv | 101 ++++++++++
 tb/tb_vga_rgb_out_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rgb_out_stage.sv
// VGA pixel output stage: tick-gated sync/video_on delay line, blanked colour register and frame counter.
// Optional VGA_TEST_PATTERN_EN replaces rgbnext with 8 vertical colour bars (pixel_x[9:7]) when test_mode = 1.
module vga_rgb_out_stage #(
  parameter int unsigned SYNC_DELAY      = 2,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned FRAME_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pixel_tick,
  input  logic [2:0]         rgbnext,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [9:0]         pixel_x,
  input  logic               test_mode,
  output logic [2:0]         rgb,
  output logic               hsync,
  output logic               vsync,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_start
);

  localparam int unsigned LAST        = SYNC_DELAY - 1;
  localparam logic        SYNC_IDLE   = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic        SYNC_ACTIVE = ~SYNC_IDLE;

  generate
    if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_sync_delay
      $error("vga_rgb_out_stage: SYNC_DELAY must be in 1..8");
    end
  endgenerate

  logic [SYNC_DELAY-1:0] r_von_dly;
  logic [SYNC_DELAY-1:0] r_hs_dly;
  logic [SYNC_DELAY-1:0] r_vs_dly;
  logic [2:0]            r_rgb;
  logic                  r_vs_prev;
  logic                  r_frame_start;
  logic [FRAME_W-1:0]    r_frame_cnt;

  logic [SYNC_DELAY:0]   w_von_chain;
  logic [SYNC_DELAY:0]   w_hs_chain;
  logic [SYNC_DELAY:0]   w_vs_chain;
  logic [2:0]            w_color;
  logic                  w_vs_rise;

  // Bit 0 is the undelayed input; bit i+1 is stage i, so a shift loads chain[SYNC_DELAY-1:0].
  assign w_von_chain = {r_von_dly, video_on};
  assign w_hs_chain  = {r_hs_dly, hsync_in};
  assign w_vs_chain  = {r_vs_dly, vsync_in};

`ifdef VGA_TEST_PATTERN_EN
  logic [6:0] w_unused_px_low;
  assign w_unused_px_low = pixel_x[6:0];
  assign w_color = test_mode ? pixel_x[9:7] : rgbnext;
`else
  logic w_unused_tp;
  assign w_unused_tp = ^{test_mode, pixel_x};
  assign w_color = rgbnext;
`endif

  assign w_vs_rise = (r_vs_dly[LAST] == SYNC_ACTIVE) && (r_vs_prev == SYNC_IDLE);

  // Delay line and colour register move together so rgb stays aligned with hsync/vsync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_von_dly <= '0;
      r_hs_dly  <= {SYNC_DELAY{SYNC_IDLE}};
      r_vs_dly  <= {SYNC_DELAY{SYNC_IDLE}};
      r_rgb     <= 3'b000;
    end else if (pixel_tick) begin
      r_von_dly <= w_von_chain[SYNC_DELAY-1:0];
      r_hs_dly  <= w_hs_chain[SYNC_DELAY-1:0];
      r_vs_dly  <= w_vs_chain[SYNC_DELAY-1:0];
      r_rgb     <= w_von_chain[LAST] ? w_color : 3'b000;
    end
  end

  // Frame counter runs every clk on the aligned vsync, independent of pixel_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_prev     <= SYNC_IDLE;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_vs_prev     <= r_vs_dly[LAST];
      r_frame_start <= w_vs_rise;
      if (w_vs_rise) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  assign rgb         = r_rgb;
  assign hsync       = r_hs_dly[LAST];
  assign vsync       = r_vs_dly[LAST];
  assign frame_cnt   = r_frame_cnt;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_rgb_out_stage.sv
// Self-checking bench for vga_rgb_out_stage: queue-based reference model plus directed literal checks.
module tb_vga_rgb_out_stage;

  localparam int unsigned SYNC_DELAY = 2;
  localparam int unsigned FRAME_W    = 8;
  localparam logic        IDLE       = 1'b1;
  localparam logic        ACT        = 1'b0;

  logic               clk        = 1'b0;
  logic               reset_n    = 1'b0;
  logic               pixel_tick = 1'b0;
  logic [2:0]         rgbnext    = 3'b000;
  logic               video_on   = 1'b0;
  logic               hsync_in   = 1'b1;
  logic               vsync_in   = 1'b1;
  logic [9:0]         pixel_x    = 10'd0;
  logic               test_mode  = 1'b0;
  logic [2:0]         rgb;
  logic               hsync;
  logic               vsync;
  logic [FRAME_W-1:0] frame_cnt;
  logic               frame_start;

  always #5 clk = ~clk;

  vga_rgb_out_stage #(
    .SYNC_DELAY(SYNC_DELAY),
    .SYNC_ACTIVE_LOW(1),
    .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pixel_tick(pixel_tick),
    .rgbnext(rgbnext),
    .video_on(video_on),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .pixel_x(pixel_x),
    .test_mode(test_mode),
    .rgb(rgb),
    .hsync(hsync),
    .vsync(vsync),
    .frame_cnt(frame_cnt),
    .frame_start(frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fs_seen = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: history of per-tick samples; outputs read SYNC_DELAY-1 samples back.
  typedef struct packed {
    logic von;
    logic hs;
    logic vs;
  } samp_t;

  samp_t              hist[$];
  logic [2:0]         m_rgb  = 3'b000;
  logic               m_hs   = IDLE;
  logic               m_vs   = IDLE;
  logic               m_vs_d = IDLE;
  logic               m_fs   = 1'b0;
  logic [FRAME_W-1:0] m_fcnt = '0;

  function automatic logic [2:0] src_color();
`ifdef VGA_TEST_PATTERN_EN
    return test_mode ? pixel_x[9:7] : rgbnext;
`else
    return rgbnext;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    samp_t last;
    if (!reset_n) begin
      hist.delete();
      m_rgb  = 3'b000;
      m_hs   = IDLE;
      m_vs   = IDLE;
      m_vs_d = IDLE;
      m_fs   = 1'b0;
      m_fcnt = '0;
    end else begin
      m_fs = (m_vs == ACT) && (m_vs_d == IDLE);
      if (m_fs) m_fcnt = m_fcnt + 8'd1;
      m_vs_d = m_vs;
      if (pixel_tick) begin
        hist.push_front({video_on, hsync_in, vsync_in});
        if (hist.size() > int'(SYNC_DELAY)) void'(hist.pop_back());
        if (hist.size() == int'(SYNC_DELAY)) last = hist[SYNC_DELAY-1];
        else last = {1'b0, IDLE, IDLE};
        m_hs  = last.hs;
        m_vs  = last.vs;
        m_rgb = last.von ? src_color() : 3'b000;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb", 32'(rgb), 32'(m_rgb));
      check("hsync", 32'(hsync), 32'(m_hs));
      check("vsync", 32'(vsync), 32'(m_vs));
      check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      check("frame_start", 32'(frame_start), 32'(m_fs));
    end
    if (frame_start === 1'b1) fs_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic v, input logic h, input logic vs, input logic [2:0] c, input int gap);
    video_on   = v;
    hsync_in   = h;
    vsync_in   = vs;
    rgbnext    = c;
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    repeat (gap) step();
  endtask

  task automatic rand_inputs();
    rgbnext   = 3'($urandom);
    video_on  = 1'($urandom);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    pixel_x   = 10'($urandom);
    test_mode = 1'($urandom);
  endtask

  int fs_base;

  initial begin
    chk_en = 1'b1;

    // Reset with random activity on every input
    reset_n = 1'b0;
    repeat (5) begin
      rand_inputs();
      pixel_tick = 1'($urandom);
      step();
    end
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);

    pixel_tick = 1'b0;
    test_mode  = 1'b0;
    do_tick(1'b0, 1'b1, 1'b1, 3'b000, 0);
    reset_n = 1'b1;
    fs_base = fs_seen;
    repeat (4) do_tick(1'b0, 1'b1, 1'b1, 3'b000, 0);
    check("release_no_fs", 32'(fs_seen - fs_base), 32'd0);

    // Latency of hsync: ticks every 4 clks
    repeat (3) do_tick(1'b1, 1'b1, 1'b1, 3'b101, 3);
    check("lat_rgb", 32'(rgb), 32'h5);
    do_tick(1'b1, 1'b0, 1'b1, 3'b101, 3);
    check("lat_hs_hold", 32'(hsync), 32'd1);
    do_tick(1'b1, 1'b0, 1'b1, 3'b101, 3);
    check("lat_hs_low", 32'(hsync), 32'd0);
    check("lat_rgb2", 32'(rgb), 32'h5);

    // Blanking follows delayed video_on
    repeat (3) do_tick(1'b1, 1'b1, 1'b1, 3'b111, 3);
    check("blank_pre", 32'(rgb), 32'h7);
    do_tick(1'b0, 1'b1, 1'b1, 3'b111, 3);
    check("blank_n1", 32'(rgb), 32'h7);
    do_tick(1'b0, 1'b1, 1'b1, 3'b111, 3);
    check("blank_n2", 32'(rgb), 32'h0);
    do_tick(1'b1, 1'b1, 1'b1, 3'b111, 3);
    check("unblank_m1", 32'(rgb), 32'h0);
    do_tick(1'b1, 1'b1, 1'b1, 3'b111, 3);
    check("unblank_m2", 32'(rgb), 32'h7);

    // Tick gating: no movement without pixel_tick
    repeat (2) do_tick(1'b1, 1'b1, 1'b1, 3'b110, 1);
    repeat (20) begin
      rand_inputs();
      pixel_tick = 1'b0;
      step();
    end
    check("gate_rgb", 32'(rgb), 32'h6);
    check("gate_hsync", 32'(hsync), 32'd1);
    check("gate_vsync", 32'(vsync), 32'd1);

    // Test pattern select (or ignored without the feature)
    test_mode = 1'b1;
    pixel_x   = 10'd384;
    repeat (2) do_tick(1'b1, 1'b1, 1'b1, 3'b101, 1);
`ifdef VGA_TEST_PATTERN_EN
    check("tp_bar3", 32'(rgb), 32'h3);
`else
    check("tp_ignored", 32'(rgb), 32'h5);
`endif
    repeat (2) do_tick(1'b0, 1'b1, 1'b1, 3'b101, 1);
    check("tp_blank", 32'(rgb), 32'h0);
    test_mode = 1'b0;

    // Randomized traffic against the model
    repeat (600) begin
      rand_inputs();
      pixel_tick = 1'($urandom_range(0, 1));
      step();
    end
    pixel_tick = 1'b0;

    // Frame counter wrap after 257 vsync pulses
    vsync_in  = 1'b1;
    test_mode = 1'b0;
    reset_n   = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    fs_base = fs_seen;
    for (int i = 0; i < 257; i++) begin
      repeat (2) do_tick(1'b1, 1'b1, 1'b0, 3'b001, 0);
      repeat (3) do_tick(1'b1, 1'b1, 1'b1, 3'b001, 0);
    end
    repeat (4) do_tick(1'b1, 1'b1, 1'b1, 3'b001, 0);
    check("fs_pulses", 32'(fs_seen - fs_base), 32'd257);
    check("fcnt_wrap", 32'(frame_cnt), 32'd1);

    // Reset mid vsync pulse clears immediately
    repeat (4) do_tick(1'b1, 1'b1, 1'b0, 3'b001, 0);
    check("fcnt_pre_rst", 32'(frame_cnt), 32'd2);
    reset_n = 1'b0;
    #2;
    check("fcnt_async", 32'(frame_cnt), 32'd0);
    check("vsync_async", 32'(vsync), 32'd1);
    step();
    vsync_in = 1'b1;
    reset_n  = 1'b1;
    fs_base  = fs_seen;
    repeat (3) do_tick(1'b1, 1'b1, 1'b1, 3'b001, 0);
    check("post_rst_fs", 32'(fs_seen - fs_base), 32'd0);
    repeat (2) do_tick(1'b1, 1'b1, 1'b0, 3'b001, 0);
    repeat (4) do_tick(1'b1, 1'b1, 1'b1, 3'b001, 0);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd1);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
